// File: rtl/model_matrix_row_summation.sv
// Streams a matrix element by element and emits one sum per row.
// A final READY pulse coincides with the last row's DATA_OUT_ENABLE.
module model_matrix_row_summation #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_I_ENABLE,
  input  logic                 DATA_IN_J_ENABLE,
  output logic                 DATA_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  typedef enum logic [1:0] {
    STARTER_STATE,
    INPUT_I_STATE,
    INPUT_J_STATE,
    ENDER_STATE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_SIZE-1:0]    size_i_q, size_i_d;
  logic [DATA_SIZE-1:0]    size_j_q, size_j_d;
  logic [CONTROL_SIZE-1:0] index_i_q, index_i_d;
  logic [CONTROL_SIZE-1:0] index_j_q, index_j_d;
  logic [DATA_SIZE-1:0]    acc_q, acc_d;
  logic                    zero_q, zero_d;
  logic                    ready_q, ready_d;
  logic                    dout_en_q, dout_en_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;

  logic last_row;
  logic last_col;

  // index_j holds the column of the most recently accepted element
  assign last_col = (DATA_SIZE'(index_j_q) + DATA_SIZE'(1)) == (size_j_q - DATA_SIZE'(1));
  assign last_row = DATA_SIZE'(index_i_q) == (size_i_q - DATA_SIZE'(1));

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    size_i_d   = size_i_q;
    size_j_d   = size_j_q;
    index_i_d  = index_i_q;
    index_j_d  = index_j_q;
    acc_d      = acc_q;
    zero_d     = zero_q;
    ready_d    = 1'b0;
    dout_en_d  = 1'b0;
    data_out_d = data_out_q;

    case (state_q)
      STARTER_STATE: begin
        if (START) begin
          size_i_d  = SIZE_I_IN;
          size_j_d  = SIZE_J_IN;
          index_i_d = '0;
          index_j_d = '0;
          acc_d     = '0;
          if ((SIZE_I_IN == '0) || (SIZE_J_IN == '0)) begin
            zero_d  = 1'b1;
            state_d = ENDER_STATE;
          end else begin
            zero_d  = 1'b0;
            state_d = INPUT_I_STATE;
          end
        end
      end
      INPUT_I_STATE: begin
        if (DATA_IN_I_ENABLE && DATA_IN_J_ENABLE) begin
          acc_d     = DATA_IN;
          index_j_d = '0;
          state_d   = (size_j_q == DATA_SIZE'(1)) ? ENDER_STATE : INPUT_J_STATE;
        end
      end
      INPUT_J_STATE: begin
        if (DATA_IN_J_ENABLE) begin
          acc_d     = acc_q + DATA_IN;
          index_j_d = index_j_q + CONTROL_SIZE'(1);
          if (last_col) begin
            state_d = ENDER_STATE;
          end
        end
      end
      ENDER_STATE: begin
        // A zero-sized pass only reports completion, never a row sum
        if (!zero_q) begin
          data_out_d = acc_q;
          dout_en_d  = 1'b1;
        end
        if (last_row || zero_q) begin
          ready_d = 1'b1;
          zero_d  = 1'b0;
          state_d = STARTER_STATE;
        end else begin
          index_i_d = index_i_q + CONTROL_SIZE'(1);
          state_d   = INPUT_I_STATE;
        end
      end
      default: state_d = STARTER_STATE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= STARTER_STATE;
      size_i_q   <= '0;
      size_j_q   <= '0;
      index_i_q  <= '0;
      index_j_q  <= '0;
      acc_q      <= '0;
      zero_q     <= 1'b0;
      ready_q    <= 1'b0;
      dout_en_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      size_i_q   <= size_i_d;
      size_j_q   <= size_j_d;
      index_i_q  <= index_i_d;
      index_j_q  <= index_j_d;
      acc_q      <= acc_d;
      zero_q     <= zero_d;
      ready_q    <= ready_d;
      dout_en_q  <= dout_en_d;
      data_out_q <= data_out_d;
    end
  end

  assign READY           = ready_q;
  assign DATA_OUT_ENABLE = dout_en_q;
  assign DATA_OUT        = data_out_q;

endmodule

// File: tb/tb_model_matrix_row_summation.sv
// Randomized and directed bench for model_matrix_row_summation; a queue of
// expected row-sum pulses is checked against the outputs on every cycle.
module tb_model_matrix_row_summation;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        READY;
  logic        DATA_IN_I_ENABLE;
  logic        DATA_IN_J_ENABLE;
  logic        DATA_OUT_ENABLE;
  logic [63:0] SIZE_I_IN;
  logic [63:0] SIZE_J_IN;
  logic [63:0] DATA_IN;
  logic [63:0] DATA_OUT;

  model_matrix_row_summation #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .READY            (READY),
    .DATA_IN_I_ENABLE (DATA_IN_I_ENABLE),
    .DATA_IN_J_ENABLE (DATA_IN_J_ENABLE),
    .DATA_OUT_ENABLE  (DATA_OUT_ENABLE),
    .SIZE_I_IN        (SIZE_I_IN),
    .SIZE_J_IN        (SIZE_J_IN),
    .DATA_IN          (DATA_IN),
    .DATA_OUT         (DATA_OUT)
  );

  typedef struct {
    int unsigned due;
    logic        ready;
    logic        doe;
    logic [63:0] sum;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] got_q[$];
  logic [63:0] exp_dout = '0;
  logic [63:0] mat [0:3][0:3];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] got_at(input int i);
    if (got_q.size() > i) return got_q[i];
    return 'x;
  endfunction

  // Per-cycle compare: outputs idle except where a pulse is expected
  always @(negedge CLK) begin
    exp_t        e;
    logic        er;
    logic        ee;
    logic [63:0] ev;
    if (DATA_OUT_ENABLE === 1'b1) got_q.push_back(DATA_OUT);
    er = 1'b0;
    ee = 1'b0;
    ev = exp_dout;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e  = exp_q.pop_front();
      er = e.ready;
      ee = e.doe;
      if (e.doe) begin
        ev       = e.sum;
        exp_dout = e.sum;
      end
    end
    check("cycle", {READY, DATA_OUT_ENABLE, DATA_OUT}, {er, ee, ev});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    START            = 1'b0;
    DATA_IN_I_ENABLE = 1'b0;
    DATA_IN_J_ENABLE = 1'b0;
    DATA_IN          = rnd64();
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // Drives one full pass over mat[0:si-1][0:sj-1] and queues the expected pulses
  task automatic run_pass(input int si, input int sj, input int max_gap, input bit junk);
    exp_t        e;
    logic [63:0] sum;
    idle();
    START     = 1'b1;
    SIZE_I_IN = 64'(si);
    SIZE_J_IN = 64'(sj);
    if (si == 0 || sj == 0) begin
      e.due = cyc + 2; e.ready = 1'b1; e.doe = 1'b0; e.sum = '0;
      exp_q.push_back(e);
      step();
      idle();
      step();
      step();
      return;
    end
    step();
    START = 1'b0;
    for (int r = 0; r < si; r++) begin
      sum = '0;
      for (int c = 0; c < sj; c++) begin
        sum += mat[r][c];
        for (int g = 0; g < int'($urandom_range(max_gap, 0)); g++) begin
          DATA_IN_J_ENABLE = 1'b0;
          DATA_IN_I_ENABLE = junk ? rbit() : 1'b0;
          DATA_IN          = rnd64();
          START            = junk ? rbit() : 1'b0;
          if (junk) begin
            SIZE_I_IN = rnd64();
            SIZE_J_IN = rnd64();
          end
          step();
        end
        DATA_IN_J_ENABLE = 1'b1;
        DATA_IN_I_ENABLE = (c == 0) ? 1'b1 : (junk ? rbit() : 1'b0);
        DATA_IN          = mat[r][c];
        START            = junk ? rbit() : 1'b0;
        if (c == sj - 1) begin
          e.due = cyc + 2; e.ready = (r == si - 1); e.doe = 1'b1; e.sum = sum;
          exp_q.push_back(e);
        end
        step();
      end
      // Bubble cycle: anything offered here must be dropped
      START            = 1'b0;
      DATA_IN_J_ENABLE = junk ? rbit() : 1'b0;
      DATA_IN_I_ENABLE = junk ? rbit() : 1'b0;
      DATA_IN          = rnd64();
      step();
    end
    idle();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    exp_q.delete();
    exp_dout = '0;
  endtask

  initial begin
    int si;
    int sj;
    RST = 1'b0;
    idle();
    SIZE_I_IN = '0;
    SIZE_J_IN = '0;
    #0 do_reset();
    step();
    step();
    check("reset", {READY, DATA_OUT_ENABLE, DATA_OUT}, 66'd0);
    RST = 1'b0;
    step();

    // 2x3 contiguous
    mat[0][0] = 1; mat[0][1] = 2; mat[0][2] = 3;
    mat[1][0] = 4; mat[1][1] = 5; mat[1][2] = 6;
    got_q.delete();
    run_pass(2, 3, 0, 0);
    step(); step();
    check("m2x3_count", 66'(got_q.size()), 66'd2);
    check("m2x3_row0", 66'(got_at(0)), 66'd6);
    check("m2x3_row1", 66'(got_at(1)), 66'd15);

    // 1x1
    mat[0][0] = 7;
    got_q.delete();
    run_pass(1, 1, 0, 0);
    step(); step();
    check("m1x1", 66'(got_at(0)), 66'd7);

    // 1x2 wrap
    mat[0][0] = '1; mat[0][1] = 2;
    got_q.delete();
    run_pass(1, 2, 0, 0);
    step(); step();
    check("wrap", 66'(got_at(0)), 66'd1);

    // 2x2 gap-free versus gapped with spurious enables
    mat[0][0] = 10; mat[0][1] = 20; mat[1][0] = 30; mat[1][1] = 40;
    got_q.delete();
    run_pass(2, 2, 0, 0);
    step(); step();
    run_pass(2, 2, 3, 1);
    step(); step();
    check("gap_count", 66'(got_q.size()), 66'd4);
    check("gap_row0", 66'(got_at(2)), 66'(got_at(0)));
    check("gap_row1", 66'(got_at(3)), 66'(got_at(1)));
    check("gap_lit0", 66'(got_at(2)), 66'd30);
    check("gap_lit1", 66'(got_at(3)), 66'd70);

    // Zero-size passes
    got_q.delete();
    run_pass(0, 3, 0, 0);
    run_pass(2, 0, 0, 0);
    step(); step();
    check("zero_no_doe", 66'(got_q.size()), 66'd0);

    // Reset after 2 of 3 elements of row 0
    mat[0][0] = 5; mat[0][1] = 6;
    idle();
    START = 1'b1; SIZE_I_IN = 2; SIZE_J_IN = 3;
    step();
    for (int c = 0; c < 2; c++) begin
      START = 1'b0; DATA_IN_I_ENABLE = (c == 0); DATA_IN_J_ENABLE = 1'b1; DATA_IN = mat[0][c];
      step();
    end
    idle();
    check("pre_rst_dout", 66'(DATA_OUT == 64'd0), 66'd0);
    do_reset();
    #1;
    check("mid_rst", {READY, DATA_OUT_ENABLE, DATA_OUT}, 66'd0);
    step();
    RST = 1'b0;
    step();
    mat[0][0] = 9;
    got_q.delete();
    run_pass(1, 1, 0, 0);
    step(); step();
    check("post_rst", 66'(got_at(0)), 66'd9);

    // Randomized passes
    for (int p = 0; p < 40; p++) begin
      si = $urandom_range(4, 1);
      sj = $urandom_range(4, 1);
      if ($urandom_range(9, 0) == 0) si = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          mat[r][c] = ($urandom_range(3, 0) == 0) ? ('1 - 64'($urandom_range(3, 0))) : rnd64();
      run_pass(si, sj, $urandom_range(3, 0), rbit());
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) step();
    end

    step(); step(); step();
    check("pending", 66'(exp_q.size()), 66'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
